// File: rtl/msp430_bus_fabric.sv
// MSP430 system-bus fabric: region decode, wait states, lane steering.
// Optional sticky vacant-access flag: define BUS_FABRIC_VACANT_FLAG_EN.
module msp430_bus_fabric #(
  parameter int unsigned          NSLV        = 4,
  parameter logic [NSLV*16-1:0]   REGION_BASE =
    {16'h4400, 16'h1C00, 16'h0200, 16'h0000},
  parameter logic [NSLV*16-1:0]   REGION_MASK =
    {16'hC000, 16'hF800, 16'hFE00, 16'hFE00},
  parameter logic [NSLV*4-1:0]    REGION_WAIT =
    {4'd2, 4'd1, 4'd0, 4'd0},
  parameter logic [15:0]          VACANT_DATA = 16'h3FFF
) (
  input  logic               MCLK,
  input  logic               rst,
`ifdef BUS_FABRIC_VACANT_FLAG_EN
  input  logic               VACANT_CLR,
  output logic               VACANT_FLG,
`endif
  input  logic               MREQ,
  input  logic [15:0]        MAB,
  input  logic [15:0]        MDBwrite,
  input  logic               MW,
  input  logic               BW,
  output logic [15:0]        MDBread,
  output logic               MRDY,
  output logic [NSLV-1:0]    S_SEL,
  output logic [15:0]        S_ADDR,
  output logic [15:0]        S_WDATA,
  output logic               S_WE,
  output logic [1:0]         S_BE,
  input  logic [NSLV*16-1:0] S_RDATA
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic            load;
  logic            capture;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [3:0]      hit_wait;

  logic [IW-1:0]   idx_q;
  logic            vac_q;
  logic            mw_q;
  logic            bw_q;

  logic [15:0]     src;
  logic [15:0]     rd_val;

  // Slice 0 sits in the LSBs; base bits outside the mask are don't-care.
  // Walking downward lets the lowest matching index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = 4'd0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((MAB & REGION_MASK[16*i +: 16]) ==
          (REGION_BASE[16*i +: 16] & REGION_MASK[16*i +: 16])) begin
        hit      = 1'b1;
        hit_idx  = IW'(i);
        hit_wait = REGION_WAIT[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MREQ) begin
          state_nxt = ACCESS;
          load      = 1'b1;
          cnt_nxt   = hit ? hit_wait : 4'd0;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      vac_q   <= 1'b0;
      mw_q    <= 1'b0;
      bw_q    <= 1'b0;
      S_ADDR  <= 16'h0000;
      S_WDATA <= 16'h0000;
      S_BE    <= 2'b00;
    end else if (load) begin
      idx_q   <= hit_idx;
      vac_q   <= ~hit;
      mw_q    <= MW;
      bw_q    <= BW;
      S_ADDR  <= BW ? MAB : {MAB[15:1], 1'b0};
      S_WDATA <= BW ? {MDBwrite[7:0], MDBwrite[7:0]}
                    : MDBwrite;
      S_BE    <= BW ? (MAB[0] ? 2'b10 : 2'b01) : 2'b11;
    end
  end

  always_comb begin
    src    = vac_q ? VACANT_DATA : S_RDATA[{idx_q, 4'b0000} +: 16];
    rd_val = src;
    if (bw_q) begin
      rd_val = {8'h00, S_ADDR[0] ? src[15:8] : src[7:0]};
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      MDBread <= 16'h0000;
    end else if (capture && !mw_q) begin
      MDBread <= rd_val;
    end
  end

  always_comb begin
    S_SEL = '0;
    if (state == ACCESS && !vac_q) begin
      S_SEL = NSLV'(1) << idx_q;
    end
  end

  assign S_WE = (state == ACCESS) && mw_q && !vac_q;
  assign MRDY = (state == DONE);

`ifdef BUS_FABRIC_VACANT_FLAG_EN
  // Set takes priority so a clear racing a new vacant hit loses.
  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      VACANT_FLG <= 1'b0;
    end else if (state == DONE && vac_q) begin
      VACANT_FLG <= 1'b1;
    end else if (VACANT_CLR) begin
      VACANT_FLG <= 1'b0;
    end
  end
`endif

endmodule
